// File: rtl/prbs_pkg.sv
// Shared PRBS-32 definitions (taps 31,30,29,27,25,0; right shift, new bit at MSB).
// Used by both generator and checker so the polynomial has a single source.
package prbs_pkg;

    localparam int unsigned PRBS_W = 32;
    localparam logic [PRBS_W-1:0] PRBS_TAP_MASK = 32'hEA00_0001;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } prbs_chk_state_t;

    function automatic logic prbs_next_bit(input logic [PRBS_W-1:0] w);
        return ^(w & PRBS_TAP_MASK);
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Error-rate window for the PRBS checker: counts accepted bits and errors per
// window and flags when the error budget of the current window is exhausted.
module prbs_err_window #(
    parameter int unsigned WIN_LEN   = 256,
    parameter int unsigned ERR_LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic err,
    input  logic restart,
    output logic limit_hit
);

    localparam int unsigned POS_W = $clog2(WIN_LEN);
    localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);

    logic [POS_W-1:0] win_pos;
    logic [ERR_W-1:0] win_err;
    logic [ERR_W-1:0] err_next;
    logic             wrap;

    // The wrap bit opens the new window, so its own error seeds the fresh count.
    always_comb begin
        wrap      = (win_pos == POS_W'(WIN_LEN - 1));
        err_next  = (wrap ? '0 : win_err) + ERR_W'(err);
        limit_hit = accept && err && (err_next == ERR_W'(ERR_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            win_pos <= '0;
            win_err <= '0;
        end else if (accept) begin
            win_pos <= wrap ? '0 : win_pos + POS_W'(1);
            win_err <= err_next;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-32 receive checker: loads the window from the line,
// verifies predictions until lock, then free-runs and counts bit errors.
module prbs_checker #(
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned WIN_LEN   = 256,
    parameter int unsigned ERR_LIMIT = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             bit_v,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    import prbs_pkg::*;

    localparam int unsigned FILL_W = $clog2(PRBS_W);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    prbs_chk_state_t   state, state_nxt;
    logic [PRBS_W-1:0] window, window_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              pred;
    logic              mismatch;
    logic              win_accept;
    logic              line_err;
    logic              restart;
    logic              limit_hit;

    assign pred       = prbs_next_bit(window);
    assign mismatch   = bit_i ^ pred;
    assign win_accept = bit_v && (state == LOCKED);
    assign line_err   = win_accept && mismatch;
    assign restart    = (state != LOCKED);

    prbs_err_window #(
        .WIN_LEN   (WIN_LEN),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_err_window (
        .clk       (clk),
        .rst       (rst),
        .accept    (win_accept),
        .err       (line_err),
        .restart   (restart),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_nxt  = state;
        window_nxt = window;
        fill_nxt   = fill;
        good_nxt   = good_cnt;
        if (bit_v) begin
            unique case (state)
                SEARCH: begin
                    window_nxt = {bit_i, window[PRBS_W-1:1]};
                    if (fill == FILL_W'(PRBS_W - 1)) begin
                        fill_nxt  = '0;
                        state_nxt = VERIFY;
                    end else begin
                        fill_nxt = fill + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    window_nxt = {bit_i, window[PRBS_W-1:1]};
                    // An all-zero window predicts zeros forever, so it never counts as good.
                    if (!mismatch && (window != '0)) begin
                        if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            good_nxt  = '0;
                            state_nxt = LOCKED;
                        end else begin
                            good_nxt = good_cnt + GOOD_W'(1);
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    window_nxt = {pred, window[PRBS_W-1:1]};
                    if (limit_hit) begin
                        state_nxt = SEARCH;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        cnt_nxt = err_cnt_o;
        if (clr_i) begin
            cnt_nxt = '0;
        end else if (line_err && (err_cnt_o != '1)) begin
            cnt_nxt = err_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            window    <= '0;
            fill      <= '0;
            good_cnt  <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            state     <= state_nxt;
            window    <= window_nxt;
            fill      <= fill_nxt;
            good_cnt  <= good_nxt;
            locked_o  <= (state_nxt == LOCKED);
            err_o     <= line_err;
            err_cnt_o <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: streams a PRBS-32 reference generator with
// injected bit errors and checks lock timing, error pulses and counters.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_i;
    logic        bit_v;
    logic        clr_i;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        sat_locked;
    logic        sat_err;
    logic [3:0]  sat_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_pulses;
    int          lock_cycles;
    logic [31:0] gen;
    logic        zero_mode;

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_CNT  (64),
        .WIN_LEN   (256),
        .ERR_LIMIT (16),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_i     (bit_i),
        .bit_v     (bit_v),
        .clr_i     (clr_i),
        .locked_o  (locked),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    // Narrow counter copy so saturation is reachable within a short run.
    prbs_checker #(
        .LOCK_CNT  (64),
        .WIN_LEN   (256),
        .ERR_LIMIT (16),
        .CNT_W     (4)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bit_i     (bit_i),
        .bit_v     (bit_v),
        .clr_i     (clr_i),
        .locked_o  (sat_locked),
        .err_o     (sat_err),
        .err_cnt_o (sat_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic flip, input logic v, input logic clr);
        bit_i = zero_mode ? 1'b0 : (gen[0] ^ flip);
        bit_v = v;
        clr_i = clr;
        @(posedge clk);
        #1;
        if (v) gen = {^(gen & 32'hEA00_0001), gen[31:1]};
        if (err) err_pulses++;
        if (locked) lock_cycles++;
        clr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bit_i       = 1'b0;
        bit_v       = 1'b0;
        clr_i       = 1'b0;
        gen         = 32'h0000_0001;
        zero_mode   = 1'b0;
        err_pulses  = 0;
        lock_cycles = 0;

        // 1: clean stream from generator reset value
        do_reset();
        check_eq("rst_locked", locked, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_cnt", err_cnt, 0);
        err_pulses = 0;
        repeat (95) step(1'b0, 1'b1, 1'b0);
        check_eq("t1_locked_95", locked, 0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t1_locked_96", locked, 1);
        check_eq("t1_no_err", err_pulses, 0);
        check_eq("t1_cnt", err_cnt, 0);

        // 2: single inverted bit
        step(1'b1, 1'b1, 1'b0);
        check_eq("t2_err", err, 1);
        check_eq("t2_cnt", err_cnt, 1);
        check_eq("t2_locked", locked, 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t2_err_clear", err, 0);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        check_eq("t2_pulses", err_pulses, 1);
        check_eq("t2_cnt_hold", err_cnt, 1);

        // 3: 16 errors in one window drop lock, then relock
        do_reset();
        repeat (96) step(1'b0, 1'b1, 1'b0);
        check_eq("t3_locked", locked, 1);
        repeat (15) step(1'b1, 1'b1, 1'b0);
        check_eq("t3_locked_15", locked, 1);
        check_eq("t3_cnt_15", err_cnt, 15);
        step(1'b1, 1'b1, 1'b0);
        check_eq("t3_unlock", locked, 0);
        check_eq("t3_cnt_16", err_cnt, 16);
        check_eq("t3_sat_cnt", sat_cnt, 4'hF);
        check_eq("t3_sat_unlock", sat_locked, 0);
        lock_cycles = 0;
        repeat (95) step(1'b0, 1'b1, 1'b0);
        check_eq("t3_relock_95", lock_cycles, 0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t3_relock_96", locked, 1);
        check_eq("t3_cnt_kept", err_cnt, 16);
        check_eq("t3_sat_kept", sat_cnt, 4'hF);

        // 4: constant-zero stream never locks
        do_reset();
        zero_mode   = 1'b1;
        lock_cycles = 0;
        repeat (500) step(1'b0, 1'b1, 1'b0);
        zero_mode = 1'b0;
        check_eq("t4_never_locked", lock_cycles, 0);
        check_eq("t4_locked", locked, 0);
        check_eq("t4_cnt", err_cnt, 0);

        // 5: bit_v toggling, then clear colliding with an error
        do_reset();
        repeat (95) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check_eq("t5_locked_95", locked, 0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t5_locked_96", locked, 1);
        step(1'b1, 1'b0, 1'b0);
        check_eq("t5_idle_err", err, 0);
        check_eq("t5_idle_cnt", err_cnt, 0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("t5_err", err, 1);
        check_eq("t5_cnt", err_cnt, 1);
        step(1'b1, 1'b1, 1'b1);
        check_eq("t5_clr_err", err, 1);
        check_eq("t5_clr_cnt", err_cnt, 0);

        // 6: reset while locked with errors counted
        repeat (5) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        check_eq("t6_cnt_5", err_cnt, 5);
        check_eq("t6_locked", locked, 1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check_eq("t6_rst_locked", locked, 0);
        check_eq("t6_rst_err", err, 0);
        check_eq("t6_rst_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
